// File: rtl/regfile_wb_sched_if.sv
// Write-back scheduler bus: groups every producer request, decode/issue
// probe and regfile write-port signal of regfile_wb_sched.
//   master : execute/memory units, issue and decode side (drives requests)
//   slave  : the scheduler (drives hold/ready, hazard and rf_* outputs)
// Signals:
//   alu_valid/alu_rd/alu_data, alu_hold    ALU write-back request / hold
//   lsu_valid/lsu_rd/lsu_data, lsu_ready   load completion handshake
//   mdu_valid/mdu_rd/mdu_data, mdu_ready   mul/div completion handshake
//   iss_valid/iss_long/iss_rd              issue-stage scoreboard set
//   dec_valid/dec_rs1/dec_rs2/dec_rd       decode-stage hazard probe
//   hazard                                 decode stall
//   rf_rd/rf_result/rf_we                  regfile write port
//   sb_err                                 sticky scoreboard error
interface regfile_wb_sched_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_hold;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic            iss_valid;
  logic            iss_long;
  logic [4:0]      iss_rd;
  logic            dec_valid;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic            hazard;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_result;
  logic            rf_we;
  logic            sb_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output iss_valid, iss_long, iss_rd,
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  alu_hold, lsu_ready, mdu_ready,
    input  hazard, rf_rd, rf_result, rf_we, sb_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  iss_valid, iss_long, iss_rd,
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    output alu_hold, lsu_ready, mdu_ready,
    output hazard, rf_rd, rf_result, rf_we, sb_err
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the single-write-port integer register file.
// Arbitrates the write port between ALU (priority), LSU and MDU (round-robin
// with an anti-starvation override), and keeps a pending-write scoreboard
// for long-latency destinations that drives the decode hazard.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_sched_if.slave (requests, handshakes, hazard, rf_*)
// Optional feature macro: SB_BYPASS_EN -- a pending register being written
// by LSU/MDU this cycle no longer stalls its rs1/rs2 readers.
module regfile_wb_sched #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_sched_if.slave  bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {RR_LSU = 1'b0, RR_MDU = 1'b1} rr_t;

  rr_t             rr_q, rr_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            sb_err_q, sb_err_d;

  logic            alu_req, lsu_req, mdu_req, lm_req;
  logic            force_lm, grant_alu, grant_lm, grant_lsu, grant_mdu;
  logic            pick_lsu;
  logic [4:0]      lm_rd;
  logic [NREG-1:0] pend_rs;

  // Requests; x0 destinations never count as writes.
  assign alu_req = rst_n && bus.alu_valid && (bus.alu_rd != 5'd0);
  assign lsu_req = rst_n && bus.lsu_valid && (bus.lsu_rd != 5'd0);
  assign mdu_req = rst_n && bus.mdu_valid && (bus.mdu_rd != 5'd0);
  assign lm_req  = lsu_req || mdu_req;

  // Round-robin winner only matters when both long units ask.
  assign pick_lsu = lsu_req && (!mdu_req || (rr_q == RR_LSU));

  // A starved LSU/MDU request pre-empts the ALU once the counter saturates.
  assign force_lm  = lm_req && (wait_q >= CW'(MAX_WAIT));
  assign grant_alu = alu_req && !force_lm;
  assign grant_lm  = lm_req && (!alu_req || force_lm);
  assign grant_lsu = grant_lm && pick_lsu;
  assign grant_mdu = grant_lm && !pick_lsu;
  assign lm_rd     = grant_lsu ? bus.lsu_rd : bus.mdu_rd;

  // x0 completions are acknowledged without consuming the write port.
  assign bus.lsu_ready = grant_lsu || (rst_n && bus.lsu_valid && (bus.lsu_rd == 5'd0));
  assign bus.mdu_ready = grant_mdu || (rst_n && bus.mdu_valid && (bus.mdu_rd == 5'd0));
  assign bus.alu_hold  = alu_req && !grant_alu;

  always_comb begin
    bus.rf_we     = 1'b0;
    bus.rf_rd     = 5'd0;
    bus.rf_result = '0;
    if (grant_alu) begin
      bus.rf_we     = 1'b1;
      bus.rf_rd     = bus.alu_rd;
      bus.rf_result = bus.alu_data;
    end else if (grant_lsu) begin
      bus.rf_we     = 1'b1;
      bus.rf_rd     = bus.lsu_rd;
      bus.rf_result = bus.lsu_data;
    end else if (grant_mdu) begin
      bus.rf_we     = 1'b1;
      bus.rf_rd     = bus.mdu_rd;
      bus.rf_result = bus.mdu_data;
    end
  end

  always_comb begin
    rr_d      = rr_q;
    wait_d    = wait_q;
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    if (grant_lm) begin
      rr_d   = grant_lsu ? RR_MDU : RR_LSU;
      wait_d = '0;
      if (!pending_q[lm_rd]) sb_err_d = 1'b1;
      pending_d[lm_rd] = 1'b0;
    end else if (lm_req && alu_req) begin
      wait_d = wait_q + CW'(1);
    end
    // Applied after the clear so a same-cycle re-issue keeps the bit set.
    if (bus.iss_valid && bus.iss_long && (bus.iss_rd != 5'd0))
      pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= RR_LSU;
      wait_q    <= '0;
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

`ifdef SB_BYPASS_EN
  // The regfile forwards this cycle's write to its read ports.
  always_comb begin
    pend_rs = pending_q;
    if (grant_lm) pend_rs[lm_rd] = 1'b0;
  end
`else
  assign pend_rs = pending_q;
`endif

  assign bus.hazard = rst_n && bus.dec_valid &&
                      (pend_rs[bus.dec_rs1] || pend_rs[bus.dec_rs2] ||
                       pending_q[bus.dec_rd]);
  assign bus.sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

  logic clk;
  logic rst_n;
  int   ntests;
  int   nfail;
  int   ai;
  logic forced;

`ifdef SB_BYPASS_EN
  localparam logic HZ_WRITE_CYCLE = 1'b0;
`else
  localparam logic HZ_WRITE_CYCLE = 1'b1;
`endif

  regfile_wb_sched_if #(.XLEN(32)) bus ();

  regfile_wb_sched #(.XLEN(32), .NREG(32), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = 5'd0; bus.mdu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_long = 1'b0; bus.iss_rd = 5'd0;
    bus.dec_valid = 1'b0; bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    bus.iss_valid = 1'b1; bus.iss_long = 1'b1; bus.iss_rd = rd;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_sb_err", {31'd0, bus.sb_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    idle();
    rst_n = 1'b0;

    // Reset state with traffic present
    @(negedge clk);
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd5;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd5;
    #1;
    chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    chk("rst_rf_we",     {31'd0, bus.rf_we},     32'd0);
    chk("rst_sb_err",    {31'd0, bus.sb_err},    32'd0);
    chk("rst_hazard",    {31'd0, bus.hazard},    32'd0);

    // Reset mid-traffic
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    issue_long(5'd5);
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd5;
    #1;
    chk("same_cycle_issue_no_hazard", {31'd0, bus.hazard}, 32'd0);
    @(negedge clk);
    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd5;
    #1;
    chk("pend5_hazard", {31'd0, bus.hazard}, 32'd1);
    rst_n = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd5; bus.lsu_data = 32'h55;
    #1;
    chk("midrst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    chk("midrst_rf_we",     {31'd0, bus.rf_we},     32'd0);
    chk("midrst_sb_err",    {31'd0, bus.sb_err},    32'd0);
    chk("midrst_hazard",    {31'd0, bus.hazard},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    chk("postrst_rf_rd",     {27'd0, bus.rf_rd},     32'd5);
    chk("postrst_hazard",    {31'd0, bus.hazard},    32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("postrst_sb_err", {31'd0, bus.sb_err}, 32'd1);
    reset_pulse();

    // Concurrent ALU/LSU/MDU with starvation override
    @(negedge clk);
    idle();
    issue_long(5'd7);
    @(negedge clk);
    issue_long(5'd9);
    ai = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle();
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(16 + ai);
      bus.alu_data  = 32'h11 + 32'(ai);
      bus.lsu_valid = (c <= 4); bus.lsu_rd = 5'd7; bus.lsu_data = 32'hAA;
      bus.mdu_valid = 1'b1;     bus.mdu_rd = 5'd9; bus.mdu_data = 32'hBB;
      forced = (c == 4) || (c == 9);
      #1;
      if (c == 4) begin
        chk("conc_c4_rf_rd",     {27'd0, bus.rf_rd},     32'd7);
        chk("conc_c4_rf_result", bus.rf_result,          32'hAA);
        chk("conc_c4_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
        chk("conc_c4_alu_hold",  {31'd0, bus.alu_hold},  32'd1);
      end else if (c == 9) begin
        chk("conc_c9_rf_rd",     {27'd0, bus.rf_rd},     32'd9);
        chk("conc_c9_rf_result", bus.rf_result,          32'hBB);
        chk("conc_c9_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
        chk("conc_c9_alu_hold",  {31'd0, bus.alu_hold},  32'd1);
      end else begin
        chk("conc_alu_rf_rd",     {27'd0, bus.rf_rd},     32'(16 + ai));
        chk("conc_alu_rf_result", bus.rf_result,          32'h11 + 32'(ai));
        chk("conc_alu_hold",      {31'd0, bus.alu_hold},  32'd0);
        chk("conc_alu_lm_ready",  {30'd0, bus.lsu_ready, bus.mdu_ready}, 32'd0);
      end
      if (!forced) ai++;
    end
    @(negedge clk);
    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd7; bus.dec_rs2 = 5'd9;
    #1;
    chk("conc_hazard_cleared", {31'd0, bus.hazard}, 32'd0);
    chk("conc_sb_err",         {31'd0, bus.sb_err}, 32'd0);

    // Round-robin fairness without ALU traffic
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle();
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hA0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd11; bus.mdu_data = 32'hB0;
      #1;
      chk("rr_rf_rd",     {27'd0, bus.rf_rd},     (c % 2 == 0) ? 32'd10 : 32'd11);
      chk("rr_lsu_ready", {31'd0, bus.lsu_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_mdu_ready", {31'd0, bus.mdu_ready}, (c % 2 == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("rr_sb_err_nonpending", {31'd0, bus.sb_err}, 32'd1);
    reset_pulse();

    // Scoreboard RAW hazard through an MDU write
    @(negedge clk);
    idle();
    issue_long(5'd12);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle();
      bus.dec_valid = 1'b1; bus.dec_rs2 = 5'd12;
      #1;
      chk("raw_hazard_wait", {31'd0, bus.hazard}, 32'd1);
    end
    @(negedge clk);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'hCC;
    #1;
    chk("raw_mdu_ready",   {31'd0, bus.mdu_ready}, 32'd1);
    chk("raw_rf_rd",       {27'd0, bus.rf_rd},     32'd12);
    chk("raw_rf_result",   bus.rf_result,          32'hCC);
    chk("raw_hazard_wcyc", {31'd0, bus.hazard},    {31'd0, HZ_WRITE_CYCLE});
    @(negedge clk);
    bus.mdu_valid = 1'b0;
    #1;
    chk("raw_hazard_after", {31'd0, bus.hazard}, 32'd0);

    // WAW hazard is never bypassed
    @(negedge clk);
    idle();
    issue_long(5'd13);
    @(negedge clk);
    idle();
    bus.dec_valid = 1'b1; bus.dec_rd = 5'd13;
    #1;
    chk("waw_hazard", {31'd0, bus.hazard}, 32'd1);
    @(negedge clk);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_data = 32'hDD;
    #1;
    chk("waw_lsu_ready",   {31'd0, bus.lsu_ready}, 32'd1);
    chk("waw_hazard_wcyc", {31'd0, bus.hazard},    32'd1);
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    #1;
    chk("waw_hazard_after", {31'd0, bus.hazard}, 32'd0);
    chk("waw_sb_err",       {31'd0, bus.sb_err}, 32'd0);

    // x0 handling
    @(negedge clk);
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    #1;
    chk("x0_alu_rf_we", {31'd0, bus.rf_we},    32'd0);
    chk("x0_alu_hold",  {31'd0, bus.alu_hold}, 32'd0);
    @(negedge clk);
    idle();
    issue_long(5'd0);
    @(negedge clk);
    idle();
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h99;
    #1;
    chk("x0_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("x0_mdu_rf_we", {31'd0, bus.rf_we},     32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h77;
    #1;
    chk("x0_mdu_with_alu_ready", {31'd0, bus.mdu_ready}, 32'd1);
    chk("x0_alu_rf_rd",          {27'd0, bus.rf_rd},     32'd20);
    chk("x0_alu_rf_result",      bus.rf_result,          32'h77);
    chk("x0_alu_hold_granted",   {31'd0, bus.alu_hold},  32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("x0_sb_err", {31'd0, bus.sb_err}, 32'd0);

    // Set/clear collision on the same register
    @(negedge clk);
    idle();
    issue_long(5'd4);
    @(negedge clk);
    idle();
    issue_long(5'd4);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h44;
    #1;
    chk("coll_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    chk("coll_rf_rd",     {27'd0, bus.rf_rd},     32'd4);
    @(negedge clk);
    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd4;
    #1;
    chk("coll_still_pending", {31'd0, bus.hazard}, 32'd1);
    chk("coll_sb_err",        {31'd0, bus.sb_err}, 32'd0);
    @(negedge clk);
    idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h45;
    #1;
    chk("coll_second_ready", {31'd0, bus.lsu_ready}, 32'd1);
    @(negedge clk);
    idle();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd4;
    #1;
    chk("coll_cleared",     {31'd0, bus.hazard}, 32'd0);
    chk("coll_sb_err_end",  {31'd0, bus.sb_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
